// File: rtl/i2s_dac_tx_pkg.sv
// Shared definitions for the WM8731 I2S DAC transmit path.
`timescale 1ns/1ps
package i2s_dac_tx_pkg;

  localparam int I2S_STD        = 0;
  localparam int I2S_LJ         = 1;
  localparam int DEFAULT_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    LEFT,
    RIGHT
  } tx_state_e;

endpackage

// File: rtl/i2s_frame_fifo.sv
// Stereo frame FIFO: one entry holds {left, right}; level counts stored frames.
`timescale 1ns/1ps
module i2s_frame_fifo
  import i2s_dac_tx_pkg::*;
#(
  parameter int WIDTH = 2 * DEFAULT_DATA_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// Serialises stereo PCM frames onto the codec DAC data pin, slaved to the
// codec-driven BCLK/LRCK which are oversampled on the system clock.
`timescale 1ns/1ps
module i2s_dac_tx
  import i2s_dac_tx_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int LEFT_JUST  = I2S_STD
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          aud_bclk_i,
  input  logic                          aud_daclrck_i,
  output logic                          aud_dacdat_o,
  input  logic                          enable_i,
  input  logic [DATA_W-1:0]             sample_left_i,
  input  logic [DATA_W-1:0]             sample_right_i,
  input  logic                          sample_valid_i,
  output logic                          sample_ready_o,
  output logic                          underrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic bclk_s1, bclk_s2, bclk_h;
  logic lrck_s1, lrck_s2, lrck_h;
  logic fall_b, lrck_fall, lrck_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      {bclk_s1, bclk_s2, bclk_h} <= '0;
      {lrck_s1, lrck_s2, lrck_h} <= '0;
    end else begin
      {bclk_s1, bclk_s2, bclk_h} <= {aud_bclk_i, bclk_s1, bclk_s2};
      {lrck_s1, lrck_s2, lrck_h} <= {aud_daclrck_i, lrck_s1, lrck_s2};
    end
  end

  assign fall_b    = bclk_h & ~bclk_s2;
  assign lrck_fall = lrck_h & ~lrck_s2;
  assign lrck_rise = ~lrck_h & lrck_s2;

  logic [2*DATA_W-1:0] fifo_rd;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop_frame;

  i2s_frame_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (sample_valid_i),
    .wr_data ({sample_left_i, sample_right_i}),
    .pop     (pop_frame),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level_o)
  );

  assign sample_ready_o = !fifo_full;

  tx_state_e state, state_next;
  logic      load_left, load_right, underrun_set, idle;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // IDLE waits for LRCK high so a reset during a low LRCK cannot fake a frame start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (lrck_s2)   state_next = ARM;
      ARM:     if (lrck_fall) state_next = LEFT;
      LEFT:    if (lrck_rise) state_next = RIGHT;
      RIGHT:   if (lrck_fall) state_next = LEFT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    idle         = (state == IDLE);
    load_left    = ((state == ARM) || (state == RIGHT)) && lrck_fall;
    load_right   = (state == LEFT) && lrck_rise;
    pop_frame    = load_left && enable_i && !fifo_empty;
    underrun_set = load_left && enable_i && fifo_empty;
  end

  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] frame_r;
  logic [DATA_W-1:0] load_word;
  logic [CNT_W-1:0]  bit_cnt;

  assign load_word = load_left ? (pop_frame ? fifo_rd[2*DATA_W-1:DATA_W] : '0) : frame_r;

  // In I2S mode the edge cycle only loads the word, so the first slot carries the pad bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q      <= '0;
      frame_r      <= '0;
      bit_cnt      <= '0;
      aud_dacdat_o <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      underrun_o <= underrun_set;
      if (idle) begin
        shift_q      <= '0;
        bit_cnt      <= '0;
        aud_dacdat_o <= 1'b0;
      end else if (load_left || load_right) begin
        if (load_left) frame_r <= pop_frame ? fifo_rd[DATA_W-1:0] : '0;
        if (LEFT_JUST == I2S_LJ) begin
          aud_dacdat_o <= load_word[DATA_W-1];
          shift_q      <= {load_word[DATA_W-2:0], 1'b0};
          bit_cnt      <= CNT_W'(DATA_W - 1);
        end else begin
          shift_q      <= load_word;
          bit_cnt      <= CNT_W'(DATA_W);
        end
      end else if (fall_b) begin
        if (bit_cnt != '0) begin
          aud_dacdat_o <= shift_q[DATA_W-1];
          shift_q      <= {shift_q[DATA_W-2:0], 1'b0};
          bit_cnt      <= bit_cnt - CNT_W'(1);
        end else begin
          aud_dacdat_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: two instances (I2S and left-justified) share stimulus and
// are checked slot-by-slot against a frame-level model of the codec link.
`timescale 1ns/1ps
module tb_i2s_dac_tx;
  import i2s_dac_tx_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bclk = 1'b0;
  logic        lrck = 1'b0;
  logic        enable = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] sample_l = '0;
  logic [15:0] sample_r = '0;

  logic        dat_std, dat_lj, ready_std, ready_lj, under_std, under_lj;
  logic [2:0]  level_std, level_lj;

  i2s_dac_tx #(.DATA_W(16), .FIFO_DEPTH(DEPTH), .LEFT_JUST(I2S_STD)) dut_std (
    .clk(clk), .rst(rst), .aud_bclk_i(bclk), .aud_daclrck_i(lrck),
    .aud_dacdat_o(dat_std), .enable_i(enable), .sample_left_i(sample_l),
    .sample_right_i(sample_r), .sample_valid_i(valid), .sample_ready_o(ready_std),
    .underrun_o(under_std), .fifo_level_o(level_std)
  );

  i2s_dac_tx #(.DATA_W(16), .FIFO_DEPTH(DEPTH), .LEFT_JUST(I2S_LJ)) dut_lj (
    .clk(clk), .rst(rst), .aud_bclk_i(bclk), .aud_daclrck_i(lrck),
    .aud_dacdat_o(dat_lj), .enable_i(enable), .sample_left_i(sample_l),
    .sample_right_i(sample_r), .sample_valid_i(valid), .sample_ready_o(ready_lj),
    .underrun_o(under_lj), .fifo_level_o(level_lj)
  );

  always #10 clk = ~clk;

  // Codec master: BCLK = clk/16, LRCK flips on a BCLK fall every 32 bit clocks.
  int bclk_falls = 0;
  initial begin
    #3;
    forever begin
      #160 bclk = 1'b1;
      #160 bclk = 1'b0;
      bclk_falls++;
      if (bclk_falls == 32) begin
        bclk_falls = 0;
        lrck = ~lrck;
      end
    end
  end

  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] fl_mem [256];
  logic [15:0] fr_mem [256];
  int          wr = 0;
  int          rd = 0;
  int          reset_rd = 0;
  int          reset_epoch = 0;
  int          epoch_seen = 0;
  int          exp_under = 0;
  int          n_under_std = 0;
  int          n_under_lj = 0;
  int          n_left = 0;
  int          nslot = 0;
  bit          armed = 1'b0;
  bit          frame_live = 1'b0;
  logic        prev_lr = 1'b0;
  logic [15:0] cur_fr = '0;
  logic [31:0] obs_std = '0, obs_lj = '0, exp_std = '0, exp_lj = '0;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Channel-level model: each LRCK half is 32 slots; a word of 16 bits sits at
  // slot 1 (I2S) or slot 0 (left-justified), everything else is zero.
  task automatic monitor_loop();
    logic [15:0] w;
    forever begin
      @(posedge bclk);
      if (epoch_seen != reset_epoch) begin
        epoch_seen = reset_epoch;
        rd = reset_rd;
        armed = 1'b0;
        frame_live = 1'b0;
        obs_std = '0; obs_lj = '0; exp_std = '0; exp_lj = '0;
        nslot = 0;
      end
      if (lrck !== prev_lr) begin
        if (nslot > 0) begin
          check_output("word_std", 64'(obs_std), 64'(exp_std));
          check_output("word_lj", 64'(obs_lj), 64'(exp_lj));
        end
        w = '0;
        if (lrck == 1'b0) begin
          n_left++;
          frame_live = armed;
          cur_fr = '0;
          if (armed && enable) begin
            if (wr != rd) begin
              w = fl_mem[rd];
              cur_fr = fr_mem[rd];
              rd++;
            end else begin
              exp_under++;
            end
          end
        end else if (frame_live) begin
          w = cur_fr;
        end
        exp_std = {1'b0, w, 15'b0};
        exp_lj  = {w, 16'b0};
        obs_std = '0; obs_lj = '0; nslot = 0;
        check_output("level_std", 64'(level_std), 64'(wr - rd));
        check_output("level_lj", 64'(level_lj), 64'(wr - rd));
        check_output("ready", 64'(ready_std), 64'((wr - rd) < DEPTH));
        check_output("underruns_std", 64'(n_under_std), 64'(exp_under));
        check_output("underruns_lj", 64'(n_under_lj), 64'(exp_under));
      end
      prev_lr = lrck;
      obs_std = {obs_std[30:0], dat_std};
      obs_lj  = {obs_lj[30:0], dat_lj};
      nslot++;
      if (lrck && !rst) armed = 1'b1;
    end
  endtask

  task automatic count_underruns();
    forever begin
      @(posedge clk);
      #1;
      if (under_std === 1'b1) n_under_std++;
      if (under_lj === 1'b1) n_under_lj++;
    end
  endtask

  // Caller is at a negedge of clk; returns at a negedge with valid dropped.
  task automatic push_frame(input logic [15:0] l, input logic [15:0] r, input int max_wait,
                            output bit acc, output int waited);
    acc = 1'b0;
    waited = 0;
    sample_l = l;
    sample_r = r;
    valid = 1'b1;
    forever begin
      acc = (ready_std === 1'b1);
      @(posedge clk);
      #1;
      if (acc || waited >= max_wait) break;
      waited++;
      @(negedge clk);
    end
    if (acc) begin
      fl_mem[wr] = l;
      fr_mem[wr] = r;
      wr++;
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_lefts(input int n);
    int target;
    int budget;
    target = n_left + n;
    budget = 0;
    while (n_left < target && budget < 80 * n) begin
      @(posedge bclk);
      budget++;
    end
    check_output("left_frames_seen", 64'(n_left >= target), 64'(1));
  endtask

  task automatic go_window();
    @(posedge bclk);
    @(negedge clk);
  endtask

  initial begin
    bit acc;
    int waited;
    fork
      monitor_loop();
      count_underruns();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_dat_std", 64'(dat_std), 64'(0));
    check_output("rst_dat_lj", 64'(dat_lj), 64'(0));
    check_output("rst_ready", 64'(ready_std), 64'(1));
    check_output("rst_underrun", 64'(under_std), 64'(0));
    check_output("rst_level", 64'(level_std), 64'(0));

    for (int i = 0; i < 100 && lrck !== 1'b0; i++) @(posedge bclk);
    @(negedge clk);
    rst = 1'b0;
    reset_rd = wr;
    reset_epoch++;
    enable = 1'b1;
    $display("[TB] standard frame A5C3/0FF0");
    push_frame(16'hA5C3, 16'h0FF0, 1, acc, waited);
    check_output("first_push_acc", 64'(acc), 64'(1));
    check_output("first_push_level", 64'(level_std), 64'(wr - rd));
    wait_lefts(4);

    $display("[TB] random frames");
    go_window();
    for (int i = 0; i < 3; i++) begin
      push_frame(16'($urandom), 16'($urandom), 1, acc, waited);
      check_output("rand_push_acc", 64'(acc), 64'(1));
    end
    wait_lefts(5);

    $display("[TB] backpressure");
    go_window();
    for (int i = 0; i < 4; i++) begin
      push_frame(16'($urandom), 16'($urandom), 0, acc, waited);
      check_output("bp_push_acc", 64'(acc), 64'(1));
    end
    check_output("bp_ready_low", 64'(ready_std), 64'((wr - rd) < DEPTH));
    check_output("bp_level_full", 64'(level_std), 64'(wr - rd));
    push_frame(16'($urandom), 16'($urandom), 3000, acc, waited);
    check_output("bp_fifth_accepted", 64'(acc), 64'(1));
    check_output("bp_fifth_held", 64'(waited > 0), 64'(1));
    wait_lefts(7);

    $display("[TB] disable mid-frame");
    go_window();
    for (int i = 0; i < 2; i++) begin
      push_frame(16'($urandom), 16'($urandom), 1, acc, waited);
      check_output("dis_push_acc", 64'(acc), 64'(1));
    end
    wait_lefts(1);
    @(negedge clk);
    enable = 1'b0;
    wait_lefts(2);
    @(negedge clk);
    enable = 1'b1;
    wait_lefts(3);

    $display("[TB] reset mid-frame");
    go_window();
    for (int i = 0; i < 2; i++) begin
      push_frame(16'($urandom), 16'($urandom), 1, acc, waited);
      check_output("rstmid_push_acc", 64'(acc), 64'(1));
    end
    wait_lefts(1);
    @(negedge clk);
    rst = 1'b1;
    reset_rd = wr;
    reset_epoch++;
    @(negedge clk);
    rst = 1'b0;
    check_output("rstmid_dat_std", 64'(dat_std), 64'(0));
    check_output("rstmid_dat_lj", 64'(dat_lj), 64'(0));
    check_output("rstmid_level", 64'(level_std), 64'(0));
    check_output("rstmid_ready", 64'(ready_std), 64'(1));
    push_frame(16'($urandom), 16'($urandom), 1, acc, waited);
    check_output("rstmid_push_acc", 64'(acc), 64'(1));
    wait_lefts(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
